// File: rtl/continuous_monitoring_system_pkg.sv
// rtl/continuous_monitoring_system_pkg.sv - shared types and constants for the trace gate
package continuous_monitoring_system_pkg;

  typedef enum logic [1:0] {
    GATE_IDLE    = 2'd0,
    GATE_ARMED   = 2'd1,
    GATE_TRACING = 2'd2,
    GATE_DONE    = 2'd3
  } gate_state_t;

  typedef enum logic [3:0] {
    GATE_START_ADDR = 4'd0,
    GATE_END_ADDR   = 4'd1,
    GATE_TRIG_CFG   = 4'd2,
    GATE_RANGE_EN   = 4'd3,
    GATE_PKT_LIMIT  = 4'd4,
    GATE_ARM        = 4'd5,
    GATE_DISARM     = 4'd6,
    GATE_RANGE0_LO  = 4'd8,
    GATE_RANGE0_HI  = 4'd9,
    GATE_RANGE1_LO  = 4'd10,
    GATE_RANGE1_HI  = 4'd11,
    GATE_RANGE2_LO  = 4'd12,
    GATE_RANGE2_HI  = 4'd13,
    GATE_RANGE3_LO  = 4'd14,
    GATE_RANGE3_HI  = 4'd15
  } gate_ctrl_addr_t;

  localparam int GATE_TRIG_START_EN = 0;
  localparam int GATE_TRIG_END_EN   = 1;
  localparam int GATE_TRIG_REARM    = 2;
  localparam int GATE_MAX_RANGES    = 4;

endpackage

// File: rtl/cms_trace_gate_if.sv
// rtl/cms_trace_gate_if.sv - output packet stream between trace gate and packer
interface cms_trace_gate_if #(
  parameter int PKT_WIDTH = 512
);
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [PKT_WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/cms_gate_fifo2.sv
// rtl/cms_gate_fifo2.sv - 2-entry valid/ready buffer; head register drives the output directly
module cms_gate_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign pop       = out_valid && out_ready;
  assign full      = (count_q == 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;

  // Caller only asserts in_valid when there is room (or a pop frees it).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (in_valid) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (in_valid && pop) begin
          head_d = in_data;
        end else if (in_valid) begin
          tail_d  = in_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (in_valid) tail_d = in_data;
          else          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/cms_trace_gate.sv
// rtl/cms_trace_gate.sv - arm/trace/done trace gate with address windows and 2-entry output buffer
// Optional: CMS_TRACE_GATE_DROP_COUNT_EN enables the saturating dropped_count.
module cms_trace_gate
  import continuous_monitoring_system_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int PKT_WIDTH       = 512,
  parameter int NUM_RANGES      = 4,
  parameter int CTRL_DATA_WIDTH = 64,
  parameter int LIMIT_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [XLEN-1:0]            pc,
  input  logic                       pc_valid,
  input  logic [PKT_WIDTH-1:0]       pkt_in,
  input  logic [3:0]                 ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  input  logic                       ctrl_write_enable,
  cms_trace_gate_if.master           out_if,
  output logic [1:0]                 state,
  output logic [LIMIT_WIDTH-1:0]     pkt_count,
  output logic [31:0]                dropped_count
);
  logic [XLEN-1:0]        start_addr_q, start_addr_d, end_addr_q, end_addr_d;
  logic [2:0]             trig_cfg_q, trig_cfg_d;
  logic [NUM_RANGES-1:0]  range_en_q, range_en_d;
  logic [LIMIT_WIDTH-1:0] pkt_limit_q, pkt_limit_d, pkt_count_q, pkt_count_d;
  logic [XLEN-1:0]        range_lo_q [NUM_RANGES];
  logic [XLEN-1:0]        range_lo_d [NUM_RANGES];
  logic [XLEN-1:0]        range_hi_q [NUM_RANGES];
  logic [XLEN-1:0]        range_hi_d [NUM_RANGES];
  gate_state_t            state_q, state_d;

  logic [NUM_RANGES-1:0]  range_hit;
  logic                   in_range, pc_fire, start_hit, end_hit, active, capture;
  logic                   limit_hit, last_pkt, wr_arm, wr_disarm, fifo_full;
  logic [PKT_WIDTH:0]     fifo_out;

  for (genvar i = 0; i < NUM_RANGES; i++) begin : g_range
    assign range_hit[i] = range_en_q[i] && (pc >= range_lo_q[i]) && (pc <= range_hi_q[i]);
  end

  assign in_range  = (range_en_q == '0) || (|range_hit);
  assign pc_fire   = pc_valid && en;
  assign start_hit = pc_fire && (state_q == GATE_ARMED) && (pc == start_addr_q);
  // End trigger only counts once tracing, so start==end opens on the first hit.
  assign end_hit   = pc_fire && (state_q == GATE_TRACING) && trig_cfg_q[GATE_TRIG_END_EN]
                     && (pc == end_addr_q);
  assign active    = pc_fire && ((state_q == GATE_TRACING) || start_hit);
  assign capture   = active && (in_range || end_hit);
  assign limit_hit = capture && (pkt_limit_q != '0)
                     && (pkt_count_q >= pkt_limit_q - LIMIT_WIDTH'(1));
  assign last_pkt  = end_hit || limit_hit;
  assign wr_arm    = ctrl_write_enable && (ctrl_addr == GATE_ARM);
  assign wr_disarm = ctrl_write_enable && (ctrl_addr == GATE_DISARM);

  always_comb begin
    state_d     = state_q;
    pkt_count_d = pkt_count_q;
    if (capture) pkt_count_d = pkt_count_q + LIMIT_WIDTH'(1);
    if (start_hit) state_d = GATE_TRACING;
    if (last_pkt) begin
      if (trig_cfg_q[GATE_TRIG_REARM]) begin
        state_d     = GATE_ARMED;
        pkt_count_d = '0;
      end else begin
        state_d = GATE_DONE;
      end
    end
    if (wr_arm) begin
      state_d     = trig_cfg_q[GATE_TRIG_START_EN] ? GATE_ARMED : GATE_TRACING;
      pkt_count_d = '0;
    end else if (wr_disarm) begin
      state_d = GATE_IDLE;
    end
  end

  always_comb begin
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    trig_cfg_d   = trig_cfg_q;
    range_en_d   = range_en_q;
    pkt_limit_d  = pkt_limit_q;
    range_lo_d   = range_lo_q;
    range_hi_d   = range_hi_q;
    if (ctrl_write_enable) begin
      case (ctrl_addr)
        GATE_START_ADDR: start_addr_d = ctrl_wdata[XLEN-1:0];
        GATE_END_ADDR:   end_addr_d   = ctrl_wdata[XLEN-1:0];
        GATE_TRIG_CFG:   trig_cfg_d   = ctrl_wdata[2:0];
        GATE_RANGE_EN:   range_en_d   = ctrl_wdata[NUM_RANGES-1:0];
        GATE_PKT_LIMIT:  pkt_limit_d  = ctrl_wdata[LIMIT_WIDTH-1:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_RANGES; i++) begin
        if (ctrl_addr == 4'(8 + 2 * i)) range_lo_d[i] = ctrl_wdata[XLEN-1:0];
        if (ctrl_addr == 4'(9 + 2 * i)) range_hi_d[i] = ctrl_wdata[XLEN-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= GATE_IDLE;
      pkt_count_q  <= '0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      trig_cfg_q   <= '0;
      range_en_q   <= '0;
      pkt_limit_q  <= '0;
      for (int i = 0; i < NUM_RANGES; i++) begin
        range_lo_q[i] <= '0;
        range_hi_q[i] <= '1;
      end
    end else begin
      state_q      <= state_d;
      pkt_count_q  <= pkt_count_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      trig_cfg_q   <= trig_cfg_d;
      range_en_q   <= range_en_d;
      pkt_limit_q  <= pkt_limit_d;
      range_lo_q   <= range_lo_d;
      range_hi_q   <= range_hi_d;
    end
  end

  // A full buffer still accepts when the head is leaving this cycle.
  cms_gate_fifo2 #(.WIDTH(PKT_WIDTH + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (capture && (!fifo_full || out_if.out_ready)),
    .in_data   ({last_pkt, pkt_in}),
    .full      (fifo_full),
    .out_valid (out_if.out_valid),
    .out_ready (out_if.out_ready),
    .out_data  (fifo_out)
  );

  assign out_if.out_data = fifo_out[PKT_WIDTH-1:0];
  assign out_if.out_last = fifo_out[PKT_WIDTH];
  assign state           = state_q;
  assign pkt_count       = pkt_count_q;

`ifdef CMS_TRACE_GATE_DROP_COUNT_EN
  logic [31:0] dropped_count_q, dropped_count_d;

  always_comb begin
    dropped_count_d = dropped_count_q;
    if (capture && fifo_full && !out_if.out_ready && (dropped_count_q != '1))
      dropped_count_d = dropped_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dropped_count_q <= '0;
    else        dropped_count_q <= dropped_count_d;
  end

  assign dropped_count = dropped_count_q;
`else
  assign dropped_count = '0;
`endif
endmodule

// File: tb/tb_cms_trace_gate.sv
// tb/tb_cms_trace_gate.sv - scoreboard bench for cms_trace_gate
module tb_cms_trace_gate;
  import continuous_monitoring_system_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [63:0]  pc = '0;
  logic         pc_valid = 1'b0;
  logic [511:0] pkt_in = '0;
  logic [3:0]   ctrl_addr = '0;
  logic [63:0]  ctrl_wdata = '0;
  logic         ctrl_write_enable = 1'b0;
  logic [1:0]   state;
  logic [31:0]  pkt_count;
  logic [31:0]  dropped_count;

  int compared = 0;
  int mismatched = 0;
  logic [512:0] sb[$];

  cms_trace_gate_if #(.PKT_WIDTH(512)) ifc ();

  cms_trace_gate dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .en                (en),
    .pc                (pc),
    .pc_valid          (pc_valid),
    .pkt_in            (pkt_in),
    .ctrl_addr         (ctrl_addr),
    .ctrl_wdata        (ctrl_wdata),
    .ctrl_write_enable (ctrl_write_enable),
    .out_if            (ifc),
    .state             (state),
    .pkt_count         (pkt_count),
    .dropped_count     (dropped_count)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] pkt_of(input logic [63:0] p);
    return {4{p, ~p}};
  endfunction

  // Output monitor: each accepted beat is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected: got pc %h last %b, required no output", ifc.out_data[511:448], ifc.out_last);
      end else begin
        logic [512:0] exp;
        exp = sb.pop_front();
        if ({ifc.out_last, ifc.out_data} !== exp) begin
          mismatched++;
          $display("FAIL sb_data: got pc %h last %b, required pc %h last %b",
                   ifc.out_data[511:448], ifc.out_last, exp[511:448], exp[512]);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    pc_valid = 1'b0;
    ctrl_write_enable = 1'b0;
    ifc.out_ready = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    en = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [63:0] d);
    ctrl_addr = a;
    ctrl_wdata = d;
    ctrl_write_enable = 1'b1;
    @(posedge clk);
    #1 ctrl_write_enable = 1'b0;
  endtask

  task automatic issue(input logic [63:0] p);
    pc = p;
    pkt_in = pkt_of(p);
    pc_valid = 1'b1;
    @(posedge clk);
    #1 pc_valid = 1'b0;
  endtask

  task automatic test_reset();
    ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({ifc.out_valid, ifc.out_last, state, pkt_count, dropped_count} !== '0 || ifc.out_data !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: valid %b last %b state %0d cnt %0d drop %0d, required all 0",
               ifc.out_valid, ifc.out_last, state, pkt_count, dropped_count);
    end
  endtask

  task automatic test_start_end();
    do_reset();
    wr(GATE_START_ADDR, 64'h100);
    wr(GATE_END_ADDR, 64'h140);
    wr(GATE_TRIG_CFG, 64'h3);
    wr(GATE_ARM, 64'h0);
    compared++;
    if (state !== 2'd1) begin
      mismatched++;
      $display("FAIL se_armed: state %0d, required 1", state);
    end
    for (logic [63:0] p = 64'hFC; p <= 64'h144; p += 4) begin
      if (p >= 64'h100 && p <= 64'h140) sb.push_back({p == 64'h140, pkt_of(p)});
      issue(p);
    end
    compared++;
    if (state !== 2'd3 || pkt_count !== 32'd17) begin
      mismatched++;
      $display("FAIL se_done: state %0d cnt %0d, required 3 / 17", state, pkt_count);
    end
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1 compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL se_drain: %0d outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_range();
    do_reset();
    wr(GATE_RANGE0_LO, 64'h200);
    wr(GATE_RANGE0_HI, 64'h20F);
    wr(GATE_RANGE_EN, 64'h1);
    wr(GATE_ARM, 64'h0);
    compared++;
    if (state !== 2'd2) begin
      mismatched++;
      $display("FAIL rng_tracing: state %0d, required 2", state);
    end
    for (logic [63:0] p = 64'h1F8; p <= 64'h218; p += 4) begin
      if (p >= 64'h200 && p <= 64'h20F) sb.push_back({1'b0, pkt_of(p)});
      issue(p);
    end
    en = 1'b0;
    issue(64'h204);
    en = 1'b1;
    compared++;
    if (pkt_count !== 32'd4 || state !== 2'd2) begin
      mismatched++;
      $display("FAIL rng_count: cnt %0d state %0d, required 4 / 2", pkt_count, state);
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1 compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL rng_drain: %0d outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_limit_rearm();
    do_reset();
    wr(GATE_PKT_LIMIT, 64'd3);
    wr(GATE_START_ADDR, 64'h80);
    wr(GATE_TRIG_CFG, 64'h5);
    wr(GATE_ARM, 64'h0);
    for (int w = 0; w < 2; w++) begin
      issue(64'h7C);
      for (logic [63:0] p = 64'h80; p <= 64'h88; p += 4) begin
        sb.push_back({p == 64'h88, pkt_of(p)});
        issue(p);
      end
      compared++;
      if (state !== 2'd1 || pkt_count !== 32'd0) begin
        mismatched++;
        $display("FAIL lim_rearm%0d: state %0d cnt %0d, required 1 / 0", w, state, pkt_count);
      end
    end
    issue(64'h8C);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1 compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL lim_drain: %0d outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_start_eq_end();
    do_reset();
    wr(GATE_START_ADDR, 64'h300);
    wr(GATE_END_ADDR, 64'h300);
    wr(GATE_TRIG_CFG, 64'h3);
    wr(GATE_ARM, 64'h0);
    sb.push_back({1'b0, pkt_of(64'h300)}); issue(64'h300);
    compared++;
    if (state !== 2'd2) begin
      mismatched++;
      $display("FAIL seq_open: state %0d, required 2", state);
    end
    sb.push_back({1'b0, pkt_of(64'h304)}); issue(64'h304);
    sb.push_back({1'b1, pkt_of(64'h300)}); issue(64'h300);
    compared++;
    if (state !== 2'd3 || pkt_count !== 32'd3) begin
      mismatched++;
      $display("FAIL seq_close: state %0d cnt %0d, required 3 / 3", state, pkt_count);
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1 compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL seq_drain: %0d outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_drop;
`ifdef CMS_TRACE_GATE_DROP_COUNT_EN
    exp_drop = 32'd3;
`else
    exp_drop = 32'd0;
`endif
    do_reset();
    wr(GATE_ARM, 64'h0);
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [63:0] p;
      p = 64'h400 + 64'(4 * k);
      if (k < 2) sb.push_back({1'b0, pkt_of(p)});
      issue(p);
    end
    repeat (2) @(posedge clk);
    #1 compared++;
    if (ifc.out_valid !== 1'b1 || ifc.out_data !== pkt_of(64'h400)) begin
      mismatched++;
      $display("FAIL bp_hold: valid %b pc %h, required 1 / 400", ifc.out_valid, ifc.out_data[511:448]);
    end
    compared++;
    if (pkt_count !== 32'd5 || dropped_count !== exp_drop) begin
      mismatched++;
      $display("FAIL bp_counts: cnt %0d drop %0d, required 5 / %0d", pkt_count, dropped_count, exp_drop);
    end
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1 compared++;
    if (sb.size() != 0 || ifc.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_drain: %0d outstanding valid %b, required 0 / 0", sb.size(), ifc.out_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wr(GATE_ARM, 64'h0);
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) issue(64'h500 + 64'(4 * k));
    compared++;
    if (state !== 2'd2 || ifc.out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL ar_pre: state %0d valid %b, required 2 / 1", state, ifc.out_valid);
    end
    sb.delete();
    #2 rst_n = 1'b0;
    #1 compared++;
    if (ifc.out_valid !== 1'b0 || state !== 2'd0 || pkt_count !== 32'd0 || dropped_count !== 32'd0) begin
      mismatched++;
      $display("FAIL ar_flush: valid %b state %0d cnt %0d drop %0d, required 0 / 0 / 0 / 0",
               ifc.out_valid, state, pkt_count, dropped_count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    ifc.out_ready = 1'b1;
  endtask

  initial begin
    ifc.out_ready = 1'b1;
    test_reset();
    test_start_end();
    test_range();
    test_limit_rearm();
    test_start_eq_end();
    test_backpressure();
    test_async_reset();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cms_trace_gate.md
# cms_trace_gate

Parametrised trace gating and buffering stage for the continuous monitoring system. It sits between the core's retired-instruction trace (pc, instr, pre-assembled packet) and the AXI-Stream packer. It generalises single start/end triggering to a four-state arm/trace/done FSM. It supports `NUM_RANGES` independently enabled address windows, a packet-count limit, optional auto re-arm, and a 2-entry output buffer with drop accounting.

## Interface
Parameters:
- `XLEN`, 64, pc width
- `PKT_WIDTH`, 512, width of packet carried to output
- `NUM_RANGES`, 4, monitored address windows (1..4)
- `CTRL_DATA_WIDTH`, 64, control write data width
- `LIMIT_WIDTH`, 32, packet-limit and count width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  sole clock
  - `rst_n`  in  1  asynchronous, active-low reset
- Trace input:
  - `en`  in  1  global enable; low holds FSM and blocks capture
  - `pc`  in  XLEN  retired pc
  - `pc_valid`  in  1  one-cycle strobe per retired instruction
  - `pkt_in`  in  PKT_WIDTH  packet accompanying pc
- Control:
  - `ctrl_addr`  in  4  control register select (`gate_ctrl_addr_t`)
  - `ctrl_wdata`  in  CTRL_DATA_WIDTH  write data
  - `ctrl_write_enable`  in  1  level write strobe, one write per high cycle
- Output stream:
  - `out_valid`  out  1  buffer head valid
  - `out_ready`  in  1  downstream accept
  - `out_data`  out  PKT_WIDTH  buffer head packet
  - `out_last`  out  1  head is final packet of a trace window
- Status:
  - `state`  out  2  FSM state (`gate_state_t`)
  - `pkt_count`  out  LIMIT_WIDTH  packets captured this window
  - `dropped_count`  out  32  packets lost to full buffer

## Operation
- FSM states: `IDLE`=0, `ARMED`=1, `TRACING`=2, `DONE`=3.
  - `GATE_ARM` write: any state → `ARMED` (or directly `TRACING` if start trigger disabled); clears `pkt_count`.
  - `ARMED` → `TRACING` on `pc_valid & en & pc==start_addr`; the triggering instruction is a capture candidate.
  - `TRACING` → `DONE` on `pc_valid & en & pc==end_addr` with end trigger enabled, or when captured count reaches nonzero `pkt_limit`; that packet carries `out_last=1`.
  - With auto re-arm set, exit goes to `ARMED` instead of `DONE` and clears `pkt_count`.
- Qualify: `pc_valid & en & (state==TRACING or entering it) & in_range`.
  - `in_range` = pc inside any enabled window [lo, hi], inclusive; true if no window enabled.
  - End-trigger / limit packets bypass the range check, so `out_last` is always delivered.
- Control map, per `ctrl_addr`:
  - 0 `GATE_START_ADDR`
  - 1 `GATE_END_ADDR`
  - 2 `GATE_TRIG_CFG`: bit0 start enable, bit1 end enable, bit2 auto re-arm
  - 3 `GATE_RANGE_EN`: bitmask, low `NUM_RANGES` bits
  - 4 `GATE_PKT_LIMIT`: 0 = unlimited
  - 5 `GATE_ARM`
  - 6 `GATE_DISARM`: → `IDLE`
  - 8+2i / 9+2i: range i lo / hi
  - Others ignored; writes to ranges ≥ `NUM_RANGES` ignored.
- Buffer: 2-entry FIFO of {last, pkt}.
  - Qualified packet with buffer full is dropped and `dropped_count` increments, saturating at all-ones.
  - A dropped end/limit packet still drives the FSM transition.
- `pkt_count` increments per qualified packet (pushed or dropped); it wraps only when `pkt_limit`=0.

## Timing
- Reset values:
  - All outputs 0; `state`=`IDLE`.
  - Config: ranges lo=0, hi=all-ones; all enables 0; limit 0; addresses 0.
- Ctrl write takes effect the next cycle; a `pc_valid` in the same cycle uses old config.
  - Exception: `GATE_ARM`/`GATE_DISARM` override any same-cycle FSM transition.
- Latency: qualified packet at edge N is visible on `out_valid`/`out_data` after edge N (registered, 1 cycle).
- Handshake:
  - Pop on `out_valid & out_ready`; push and pop in the same cycle are allowed when full.
  - `out_data`/`out_last` stable while `out_valid & ~out_ready`.
- Start and end addresses equal, both enabled: `ARMED` → `TRACING` on the first hit, that packet captured; the next hit ends the window.
- Reset asserted mid-operation: buffer flushed immediately, counters cleared.

## Configuration
- `CMS_TRACE_GATE_DROP_COUNT_EN`:
  - Defined: 32-bit saturating `dropped_count` implemented.
  - Undefined: `dropped_count` tied to 0, counter logic removed; drop behaviour is otherwise unchanged.

## Structure
- Add to `continuous_monitoring_system_pkg`:
  - `gate_state_t`
  - `gate_ctrl_addr_t` with the map above
  - `GATE_TRIG_CFG` bit indices
  - `GATE_MAX_RANGES=4`
- Sub-module `cms_gate_fifo2`: 2-entry valid/ready buffer parametrised by width, with `full` output.
- Range comparators are generated in-module.

## Test plan
- Start=0x100, end=0x140, both enabled, arm; pc 0xFC..0x144 step 4 → 17 packets (0x100..0x140), last has `out_last`, `state`=`DONE`.
- Range0 [0x200,0x20F] enabled, start disabled, arm; pc 0x1F8..0x218 → only 0x200..0x20C output.
- `pkt_limit`=3, auto re-arm, start=0x80; 0x80 hit twice → two windows of 3 packets, each 3rd with `out_last`; `state`=`ARMED` after each.
- `out_ready`=0, 5 qualified packets → 2 buffered, `dropped_count`=3 (0 without macro); then `out_ready`=1 → first 2 packets in order.
- Reset asserted while `TRACING` with full buffer → `out_valid`=0 and `state`=`IDLE` immediately; `pkt_count`=0.
